axil_led_arbiter: RTL



---
 rtl/axil_led_arbiter.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axil_led_arbiter.sv
// -----------------------------------------------------------------------------
// axil_led_arbiter
//
// Shares one AXI4-Lite master port (towards the LED controller register
// space) between two on-chip requesters. Each requester presents a single
// word read or write on a valid/done handshake. The arbiter:
//   - grants round-robin between the two requesters,
//   - keeps exactly one AXI transaction in flight,
//   - answers requests outside [BASE_ADDR, BASE_ADDR+WINDOW_SIZE) locally with
//     DECERR (2'b11) without touching AXI,
//   - passes slave responses (OKAY/SLVERR/...) back unchanged.
//
// Ports
//   aclk, areset         clock, synchronous active-high reset
//   req_valid[1:0]       request valid, bit i = requester i (held until done)
//   req_write[1:0]       1 = write, 0 = read
//   req_addr             byte address, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata            write data, requester i at [i*32 +: 32]
//   req_wstrb            byte strobes, requester i at [i*4 +: 4]
//   req_done[1:0]        one-cycle completion pulse for the served requester
//   req_rdata            read data (0 for writes/errors), valid with req_done
//   req_resp             response code, valid with req_done
//   m_axi_*              AXI4-Lite master (32-bit data, ADDR_W address)
//
// Timing with a zero-wait slave, grant in cycle N:
//   write/read: AXI valids at N+1, req_done at N+3
//   window miss: req_done at N+2
// -----------------------------------------------------------------------------
module axil_led_arbiter #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h44A00000,
  parameter logic [ADDR_W-1:0] WINDOW_SIZE = 32'h00010000
) (
  input  logic                  aclk,
  input  logic                  areset,

  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [63:0]           req_wdata,
  input  logic [7:0]            req_wstrb,
  output logic [1:0]            req_done,
  output logic [31:0]           req_rdata,
  output logic [1:0]            req_resp,

  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,

  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,

  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,

  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,

  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_BRESP,
    ST_RD,
    ST_RDATA,
    ST_ERR,
    ST_DONE
  } state_t;

  state_t state_reg, state_next;

  // Per-requester views of the packed request buses.
  logic [ADDR_W-1:0] addr_arr   [2];
  logic [31:0]       wdata_arr  [2];
  logic [3:0]        wstrb_arr  [2];
  logic              in_window  [2];

  // Latched transaction (fields of the granted requester).
  logic              grant_reg;
  logic              last_grant_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [3:0]        wstrb_reg;
  logic              aw_done_reg;
  logic              w_done_reg;
  logic [31:0]       rdata_reg;
  logic [1:0]        resp_reg;

  logic              grant_sel;
  logic              aw_hs;
  logic              w_hs;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*32 +: 32];
      assign wstrb_arr[gi] = req_wstrb[gi*4 +: 4];

      // The offset form avoids overflow of BASE_ADDR+WINDOW_SIZE at the top
      // of the address space.
      assign in_window[gi] = (addr_arr[gi] >= BASE_ADDR) &&
                             ((addr_arr[gi] - BASE_ADDR) < WINDOW_SIZE);

      assign req_done[gi]  = (state_reg == ST_DONE) && (grant_reg == 1'(gi));
    end
  endgenerate

  // Round-robin: on contention the requester that did not win last time is
  // served; otherwise the single valid requester wins (bit 1 decides it).
  always_comb begin
    grant_sel = req_valid[1];
    if (req_valid == 2'b11) begin
      grant_sel = ~last_grant_reg;
    end
  end

  // AXI channel drives. AW and W drop independently once accepted.
  assign m_axi_awaddr  = addr_reg;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = (state_reg == ST_WR) && !aw_done_reg;
  assign m_axi_wdata   = wdata_reg;
  assign m_axi_wstrb   = wstrb_reg;
  assign m_axi_wvalid  = (state_reg == ST_WR) && !w_done_reg;
  assign m_axi_bready  = (state_reg == ST_BRESP);
  assign m_axi_araddr  = addr_reg;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = (state_reg == ST_RD);
  assign m_axi_rready  = (state_reg == ST_RDATA);

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;

  // Response fields are only driven during the done pulse.
  assign req_rdata = (state_reg == ST_DONE) ? rdata_reg : 32'h0;
  assign req_resp  = (state_reg == ST_DONE) ? resp_reg  : 2'b00;

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|req_valid) begin
          if (!in_window[grant_sel]) begin
            state_next = ST_ERR;
          end else if (req_write[grant_sel]) begin
            state_next = ST_WR;
          end else begin
            state_next = ST_RD;
          end
        end
      end
      ST_WR: begin
        // Either channel may have been accepted earlier or in this cycle.
        if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
          state_next = ST_BRESP;
        end
      end
      ST_BRESP: begin
        if (m_axi_bvalid) begin
          state_next = ST_DONE;
        end
      end
      ST_RD: begin
        if (m_axi_arready) begin
          state_next = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (m_axi_rvalid) begin
          state_next = ST_DONE;
        end
      end
      ST_ERR:  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Transaction datapath: latch at grant, track channel acceptance, capture
  // the response.
  always_ff @(posedge aclk) begin
    if (areset) begin
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      addr_reg       <= '0;
      wdata_reg      <= 32'h0;
      wstrb_reg      <= 4'h0;
      aw_done_reg    <= 1'b0;
      w_done_reg     <= 1'b0;
      rdata_reg      <= 32'h0;
      resp_reg       <= 2'b00;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|req_valid) begin
            grant_reg      <= grant_sel;
            last_grant_reg <= grant_sel;
            addr_reg       <= addr_arr[grant_sel];
            wdata_reg      <= wdata_arr[grant_sel];
            wstrb_reg      <= wstrb_arr[grant_sel];
            aw_done_reg    <= 1'b0;
            w_done_reg     <= 1'b0;
            rdata_reg      <= 32'h0;
            resp_reg       <= 2'b00;
          end
        end
        ST_WR: begin
          if (aw_hs) begin
            aw_done_reg <= 1'b1;
          end
          if (w_hs) begin
            w_done_reg <= 1'b1;
          end
        end
        ST_BRESP: begin
          if (m_axi_bvalid) begin
            resp_reg <= m_axi_bresp;
          end
        end
        ST_RDATA: begin
          if (m_axi_rvalid) begin
            rdata_reg <= m_axi_rdata;
            resp_reg  <= m_axi_rresp;
          end
        end
        ST_ERR: begin
          rdata_reg <= 32'h0;
          resp_reg  <= RESP_DECERR;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
